// File: rtl/wb_regfile_pkg.sv
// Shared CPU definitions: EX/WB bundle layout and a helper to split it into fields.
package wb_regfile_pkg;

  localparam int unsigned EXWB_W = 72;
  localparam int unsigned RES_LO = 0;
  localparam int unsigned RES_HI = 31;
  localparam int unsigned WE_BIT = 32;
  localparam int unsigned RD_LO  = 33;
  localparam int unsigned RD_HI  = 37;
  localparam int unsigned RAW    = RD_HI - RD_LO + 1;
  localparam int unsigned RESW   = RES_HI - RES_LO + 1;

  typedef struct packed {
    logic            we;
    logic [RAW-1:0]  rd;
    logic [RESW-1:0] res;
  } wb_t;

  function automatic wb_t wb_unpack(input logic [EXWB_W-1:0] bus);
    wb_t w;
    w.res = bus[RES_HI:RES_LO];
    w.we  = bus[WE_BIT];
    w.rd  = bus[RD_HI:RD_LO];
    return w;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register saturating pending-write counters and the operand stall decision.
module wb_scoreboard
  import wb_regfile_pkg::*;
#(
  parameter int unsigned NREG = 32,
  parameter int unsigned CW   = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           issue_valid,
  input  logic [RAW-1:0] issue_rd,
  input  logic           wb_we,
  input  logic [RAW-1:0] wb_rd,
  input  logic [RAW-1:0] rs_addr,
  input  logic [RAW-1:0] rt_addr,
  output logic           stall
);

  localparam logic [CW-1:0] CntMax = '1;

  logic [CW-1:0]   cnt_q [NREG];
  logic [CW-1:0]   cnt_d [NREG];
  logic [NREG-1:0] inc, dec;
  logic            stall_rs, stall_rt;

  // wb_we is already qualified with a nonzero destination.
  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      inc[i]   = issue_valid && (issue_rd == RAW'(i)) && (i != 0);
      dec[i]   = wb_we && (wb_rd == RAW'(i));
      cnt_d[i] = cnt_q[i];
      if (inc[i] && !dec[i] && (cnt_q[i] != CntMax)) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else if (dec[i] && !inc[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A single outstanding write that retires this cycle is covered by the bypass.
  assign stall_rs = (rs_addr != '0) &&
                    ((cnt_q[rs_addr] > CW'(1)) ||
                     ((cnt_q[rs_addr] == CW'(1)) && !(wb_we && (wb_rd == rs_addr))));
  assign stall_rt = (rt_addr != '0) &&
                    ((cnt_q[rt_addr] > CW'(1)) ||
                     ((cnt_q[rt_addr] == CW'(1)) && !(wb_we && (wb_rd == rt_addr))));
  assign stall    = stall_rs || stall_rt;

endmodule

// File: rtl/wb_regfile.sv
// Register file with WB bypass, writeback counter and pending-write scoreboard.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int unsigned NREG = 32,
  parameter int unsigned DW   = 32,
  parameter int unsigned CW   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [EXWB_W-1:0] wb_in,
  input  logic [RAW-1:0]    rs_addr,
  input  logic [RAW-1:0]    rt_addr,
  output logic [DW-1:0]     rs_data,
  output logic [DW-1:0]     rt_data,
  input  logic              issue_valid,
  input  logic [RAW-1:0]    issue_rd,
  output logic              stall,
  output logic [31:0]       retired
);

  wb_t         wb;
  logic        wb_we;
  logic [DW-1:0] rf_q [NREG];
  logic [31:0] retired_q, retired_d;

  assign wb    = wb_unpack(wb_in);
  assign wb_we = wb.we && (wb.rd != '0);

  assign retired_d = wb_we ? retired_q + 32'd1 : retired_q;

  // r0 is never written, so it keeps its reset value of zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
      retired_q <= '0;
    end else begin
      if (wb_we) begin
        rf_q[wb.rd] <= DW'(wb.res);
      end
      retired_q <= retired_d;
    end
  end

  always_comb begin
    rs_data = rf_q[rs_addr];
    if (rs_addr == '0) begin
      rs_data = '0;
    end else if (wb_we && (wb.rd == rs_addr)) begin
      rs_data = DW'(wb.res);
    end
  end

  always_comb begin
    rt_data = rf_q[rt_addr];
    if (rt_addr == '0) begin
      rt_data = '0;
    end else if (wb_we && (wb.rd == rt_addr)) begin
      rt_data = DW'(wb.res);
    end
  end

  assign retired = retired_q;

  wb_scoreboard #(
    .NREG(NREG),
    .CW  (CW)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .wb_we      (wb_we),
    .wb_rd      (wb.rd),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .stall      (stall)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed vector table, corner sequences, random run vs. a model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [71:0] wb_in;
  logic [4:0]  rs_addr, rt_addr, issue_rd;
  logic        issue_valid;
  logic [31:0] rs_data, rt_data, retired;
  logic        stall;

  int errors = 0;
  int checks = 0;

  localparam int CMAX = 3;

  logic [31:0] m_reg [32];
  int          m_cnt [32];
  logic [31:0] m_ret;

  wb_regfile #(
    .NREG(32),
    .DW  (32),
    .CW  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_in      (wb_in),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .stall      (stall),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        e_stall;
    logic [31:0] e_ret;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (wb_in[32] && wb_in[37:33] == a) return wb_in[31:0];
    return m_reg[a];
  endfunction

  function automatic logic m_stall_one(input logic [4:0] a);
    if (a == 0) return 1'b0;
    if (m_cnt[a] >= 2) return 1'b1;
    return (m_cnt[a] == 1) && !(wb_in[32] && wb_in[37:33] == a);
  endfunction

  // Architectural effect of one clock edge.
  task automatic m_step();
    int rd, ird;
    bit acc, inc;
    rd  = int'(wb_in[37:33]);
    ird = int'(issue_rd);
    acc = wb_in[32] && rd != 0;
    inc = issue_valid && ird != 0;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_reg[i] = 32'h0;
        m_cnt[i] = 0;
      end
      m_ret = 32'h0;
    end else begin
      if (acc) begin
        m_reg[rd] = wb_in[31:0];
        m_ret     = m_ret + 32'd1;
      end
      if (!(acc && inc && rd == ird)) begin
        if (inc && m_cnt[ird] < CMAX) m_cnt[ird]++;
        if (acc && m_cnt[rd] > 0) m_cnt[rd]--;
      end
    end
  endtask

  // Upper bits [71:38] carry random junk; they must not matter.
  task automatic drive(input bit r, input bit we, input logic [4:0] rd, input logic [31:0] res,
                       input bit iv, input logic [4:0] ird, input logic [4:0] a,
                       input logic [4:0] b);
    rst         = r;
    wb_in       = {34'($urandom), rd, we, res};
    issue_valid = iv;
    issue_rd    = ird;
    rs_addr     = a;
    rt_addr     = b;
    #2;
  endtask

  task automatic tick();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model();
    chk("rs_data", rs_data, m_read(rs_addr));
    chk("rt_data", rt_data, m_read(rt_addr));
    chk("stall", {31'b0, stall}, {31'b0, m_stall_one(rs_addr) | m_stall_one(rt_addr)});
    chk("retired", retired, m_ret);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 32'd0};
    tbl[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 32'd1};
    tbl[2]  = '{1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 32'd1};
    tbl[3]  = '{1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd5, 5'd7, 32'hDEADBEEF, 32'hA5A5A5A5,
                1'b0, 32'd1};
    tbl[4]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd7, 32'h0, 32'hA5A5A5A5, 1'b0, 32'd2};
    tbl[5]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0, 32'h0, 32'h0, 1'b1, 32'd2};
    tbl[6]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0, 32'h0, 32'h0, 1'b1, 32'd2};
    tbl[7]  = '{1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 5'd3, 5'd0, 32'h11, 32'h0, 1'b1, 32'd2};
    tbl[8]  = '{1'b1, 5'd3, 32'h22, 1'b0, 5'd0, 5'd3, 5'd0, 32'h22, 32'h0, 1'b0, 32'd3};
    tbl[9]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0, 32'h22, 32'h0, 1'b0, 32'd4};
    tbl[10] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd0, 32'h0, 32'h0, 1'b0, 32'd4};
    tbl[11] = '{1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 5'd4, 5'd0, 32'h44, 32'h0, 1'b0, 32'd4};
    tbl[12] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd0, 32'h44, 32'h0, 1'b1, 32'd5};
    tbl[13] = '{1'b0, 5'd4, 32'hFFFF, 1'b0, 5'd0, 5'd4, 5'd4, 32'h44, 32'h44, 1'b1, 32'd5};
    tbl[14] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd0, 32'h44, 32'h0, 1'b1, 32'd5};

    // Reset and reset state.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    drive(0, 0, 0, 0, 0, 0, 5, 7);
    chk("reset_rs", rs_data, 32'h0);
    chk("reset_rt", rt_data, 32'h0);
    chk("reset_stall", {31'b0, stall}, 32'h0);
    chk("reset_retired", retired, 32'h0);

    // Directed vector table.
    foreach (tbl[i]) begin
      drive(0, tbl[i].we, tbl[i].rd, tbl[i].res, tbl[i].iv, tbl[i].ird, tbl[i].rs, tbl[i].rt);
      chk($sformatf("vec%0d_rs", i), rs_data, tbl[i].e_rs);
      chk($sformatf("vec%0d_rt", i), rt_data, tbl[i].e_rt);
      chk($sformatf("vec%0d_stall", i), {31'b0, stall}, {31'b0, tbl[i].e_stall});
      chk($sformatf("vec%0d_retired", i), retired, tbl[i].e_ret);
      tick();
    end

    // Reset mid-operation drops pending counts; later WB neither underflows nor is lost.
    drive(0, 0, 0, 0, 1, 9, 0, 0);
    tick();
    drive(1, 1, 9, 32'h77, 1, 9, 9, 4);
    tick();
    drive(0, 0, 0, 0, 0, 0, 9, 4);
    chk("post_rst_stall", {31'b0, stall}, 32'h0);
    chk("post_rst_retired", retired, 32'h0);
    chk("post_rst_r9", rs_data, 32'h0);
    tick();
    drive(0, 1, 9, 32'h55, 0, 0, 9, 0);
    chk("r9_bypass", rs_data, 32'h55);
    tick();
    drive(0, 0, 0, 0, 0, 0, 9, 4);
    chk("r9_written", rs_data, 32'h55);
    chk("r9_no_underflow", {31'b0, stall}, 32'h0);
    chk("r9_retired", retired, 32'd1);
    tick();

    // Counter saturates at 3: four issues need only three writebacks to clear.
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, 8, 0, 0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 8, 32'(i), 0, 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 8, 0);
    chk("sat_one_left", {31'b0, stall}, 32'h1);
    tick();
    drive(0, 1, 8, 32'h88, 0, 0, 0, 8);
    chk("sat_last_wb", {31'b0, stall}, 32'h0);
    chk("sat_last_data", rt_data, 32'h88);
    tick();
    drive(0, 0, 0, 0, 0, 0, 8, 0);
    chk("sat_cleared", {31'b0, stall}, 32'h0);
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 39) == 0), 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)));
      chk_model();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter NREG, default 32, number of architectural registers.
REQ-002 SHALL have parameter DW, default 32, register data width.
REQ-003 SHALL have parameter CW, default 2, width of each per-register pending counter.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 wb_in  input  72  EX/WB bundle: [31:0] result, [32] write enable, [37:33] destination register, [71:38] ignored.
REQ-007 rs_addr  input  5  read port A address.
REQ-008 rt_addr  input  5  read port B address.
REQ-009 rs_data  output  32  read port A data, combinational.
REQ-010 rt_data  output  32  read port B data, combinational.
REQ-011 issue_valid  input  1  an instruction with a register destination enters EX this cycle.
REQ-012 issue_rd  input  5  destination register of the issuing instruction.
REQ-013 stall  output  1  a source operand has an outstanding write that is not written back this cycle.
REQ-014 retired  output  32  count of completed register writebacks.

Function
REQ-015 SHALL write wb_in[31:0] into register wb_in[37:33] at the clock edge when wb_in[32]=1 and wb_in[37:33]!=0.
REQ-016 SHALL hold register 0 at zero at all times; reads of address 0 SHALL return 0, and writes to it SHALL be discarded.
REQ-017 SHALL bypass data: when a read address equals a nonzero WB destination with WE=1, that read port SHALL return wb_in[31:0] in the same cycle.
REQ-018 SHALL keep one CW-bit pending counter per register; issue_valid with issue_rd!=0 SHALL increment the counter for issue_rd.
REQ-019 SHALL decrement the counter for wb_in[37:33] when WE=1 and the destination is nonzero.
REQ-020 An increment and a decrement on the same register in the same cycle SHALL leave that counter unchanged.
REQ-021 Each counter SHALL saturate at 2^CW-1 on increment and at 0 on decrement; it SHALL never wrap.
REQ-022 SHALL assert stall when rs_addr or rt_addr is nonzero and its counter is greater than 1, or equal to 1 with no WB write to that register this cycle.
REQ-023 stall SHALL be purely combinational from the current counters, rs_addr, rt_addr and wb_in; it SHALL have zero-cycle latency.
REQ-024 retired SHALL increment by 1 on each accepted write per REQ-015, wrapping from 0xFFFFFFFF to 0.
REQ-025 Writes with WE=0 SHALL change neither the register file, the counters nor retired, regardless of the other wb_in bits.

Reset
REQ-026 On rst=1 at a clock edge, all registers, all pending counters and retired SHALL clear to 0.
REQ-027 During reset, issue and writeback inputs SHALL be ignored, and stall SHALL be 0 the cycle after the reset edge.
REQ-028 Reset asserted mid-operation SHALL discard all outstanding pending counts; a WB arriving after reset SHALL still write the register and SHALL NOT underflow its counter.

Structure
REQ-029 SHALL place the bundle field positions (RES_LO=0, RES_HI=31, WE_BIT=32, RD_LO=33, RD_HI=37) in the shared CPU package, alongside the EX/WB bundle width of 72.
REQ-030 The pending-counter array and stall logic SHALL be a single sub-module named wb_scoreboard; the register file, bypass and retired counter SHALL remain in wb_regfile.

Verification
REQ-031 Write 0xDEADBEEF to r5 with WE=1; the next cycle rs_addr=5 -> rs_data=0xDEADBEEF, retired=1.
REQ-032 Apply WE=1, rd=0, data 0x1234; reading r0 -> 0, and retired is unchanged.
REQ-033 WB writes r7=0xA5A5A5A5 while rt_addr=7 in the same cycle -> rt_data=0xA5A5A5A5 in that cycle (bypass).
REQ-034 Issue rd=3 twice, then rs_addr=3 -> stall=1; first WB to r3 -> stall=1; second WB to r3 -> stall=0 in the same cycle.
REQ-035 Issue rd=4 and WB rd=4 in the same cycle with counter=1 -> counter stays 1 and stall for rs=4 is held with no WB.
REQ-036 Issue rd=9, assert rst, then WB r9=0x55 -> r9=0x55, counter[9]=0, stall=0, retired=1.
